// File: rtl/am_pkg.sv
// Constants and types shared by the AM transmit chain and the receive chain.
// Holds the DC offset, the sigma-delta feedback levels, the acc limits and the envelope target helper.
package am_pkg;

    localparam logic [15:0]        DC_OFFSET = 16'h8000;
    localparam logic signed [17:0] FB_HI     = 18'sd32767;
    localparam logic signed [17:0] FB_LO     = -18'sd32768;
    localparam logic signed [17:0] ACC_MAX   = 18'sh1FFFF;
    localparam logic signed [17:0] ACC_MIN   = 18'sh20000;

    typedef enum logic {
        ST_HOLD,
        ST_RAMP
    } env_state_t;

    // The offset audio sample always lands in 16384..49151, so the 16-bit add never wraps.
    function automatic logic [15:0] calc_target(input logic signed [15:0] audio,
                                                input logic [2:0]         depth);
        logic signed [15:0] shifted;
        shifted = audio >>> (depth + 4'd1);
        return DC_OFFSET + shifted;
    endfunction

endpackage

// File: rtl/am_mod_if.sv
// Sample, carrier and status signals between the audio/NCO side and the AM modulator.
interface am_mod_if;

    logic signed [15:0] audio_in;
    logic               in_tick;
    logic [2:0]         depth;
    logic signed [15:0] cos;
    logic               RF_out;
    logic               ramp_busy;

    modport master (
        output audio_in, in_tick, depth, cos,
        input  RF_out, ramp_busy
    );

    modport slave (
        input  audio_in, in_tick, depth, cos,
        output RF_out, ramp_busy
    );

endinterface

// File: rtl/sd_mod1.sv
// First-order sigma-delta loop turning the 16-bit modulated product into the 1-bit RF stream.
module sd_mod1
    import am_pkg::*;
(
    input  logic               CLK,
    input  logic               RSTb,
    input  logic signed [15:0] prod,
    output logic               RF_out
);

    logic signed [17:0] r_acc;
    logic signed [17:0] w_fb;
    logic signed [18:0] w_sum;
    logic signed [17:0] w_acc_next;

    // One guard bit on the sum lets the clamp catch excursions past either limit.
    always_comb begin
        w_fb  = RF_out ? FB_HI : FB_LO;
        w_sum = $signed({r_acc[17], r_acc})
              + $signed({{3{prod[15]}}, prod})
              - $signed({w_fb[17], w_fb});
        if (w_sum > $signed({ACC_MAX[17], ACC_MAX})) begin
            w_acc_next = ACC_MAX;
        end else if (w_sum < $signed({ACC_MIN[17], ACC_MIN})) begin
            w_acc_next = ACC_MIN;
        end else begin
            w_acc_next = w_sum[17:0];
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_acc  <= '0;
            RF_out <= 1'b0;
        end else begin
            r_acc  <= w_acc_next;
            RF_out <= ~w_acc_next[17];
        end
    end

endmodule

// File: rtl/am_mod.sv
// AM modulator: ramped envelope follows offset audio, multiplies the carrier, feeds sd_mod1.
// A new target loads on in_tick; the ramp step is computed from it one cycle later.
module am_mod
    import am_pkg::*;
#(
    parameter int RAMP_LOG2 = 8
) (
    input  logic     CLK,
    input  logic     RSTb,
    am_mod_if.slave  bus
);

    localparam logic [RAMP_LOG2-1:0] CNT_MAX = '1;
    localparam logic [RAMP_LOG2-1:0] CNT_ONE = RAMP_LOG2'(1);

    env_state_t              r_state;
    logic [15:0]             r_target;
    logic [15:0]             r_env_cur;
    logic signed [16:0]      r_step;
    logic [RAMP_LOG2-1:0]    r_ramp_cnt;
    logic                    r_pending;
    logic                    r_busy;
    logic signed [15:0]      r_prod;

    logic signed [17:0]      w_diff;
    logic signed [17:0]      w_shift;
    logic signed [16:0]      w_step;
    logic signed [17:0]      w_env_sum;
    logic [15:0]             w_env_next;
    logic signed [32:0]      w_mult;
    logic                    w_rf;
    logic                    w_unused;

    always_comb begin
        w_diff     = $signed({2'b00, r_target}) - $signed({2'b00, r_env_cur});
        w_shift    = w_diff >>> RAMP_LOG2;
        w_step     = w_shift[16:0];
        w_env_sum  = $signed({2'b00, r_env_cur}) + $signed({r_step[16], r_step});
        w_env_next = w_env_sum[15:0];
        w_mult     = $signed({1'b0, r_env_cur}) * bus.cos;
    end

    assign w_unused = ^{w_shift[17], w_env_sum[17:16], w_mult[32], w_mult[15:0]};

    // r_pending marks "target loaded last cycle"; it outranks ramp completion so a tick on
    // the final ramp cycle still lands env_cur on the old target before the new ramp begins.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_state    <= ST_HOLD;
            r_target   <= DC_OFFSET;
            r_env_cur  <= DC_OFFSET;
            r_step     <= '0;
            r_ramp_cnt <= '0;
            r_pending  <= 1'b0;
            r_busy     <= 1'b0;
            r_prod     <= '0;
        end else begin
            r_prod    <= w_mult[31:16];
            r_pending <= bus.in_tick;
            if (bus.in_tick) begin
                r_target <= calc_target(bus.audio_in, bus.depth);
            end
            case (r_state)
                ST_HOLD: begin
                    if (r_pending) begin
                        r_step     <= w_step;
                        r_ramp_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    if (r_pending) begin
                        r_step     <= w_step;
                        r_ramp_cnt <= '0;
                        r_env_cur  <= w_env_next;
                    end else if (r_ramp_cnt == CNT_MAX) begin
                        r_env_cur  <= r_target;
                        r_busy     <= 1'b0;
                        r_state    <= ST_HOLD;
                    end else begin
                        r_env_cur  <= w_env_next;
                        r_ramp_cnt <= r_ramp_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_HOLD;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    sd_mod1 u_sd_mod1 (
        .CLK    (CLK),
        .RSTb   (RSTb),
        .prod   (r_prod),
        .RF_out (w_rf)
    );

    assign bus.RF_out    = w_rf;
    assign bus.ramp_busy = r_busy;

endmodule

// File: tb/tb_am_mod.sv
// Scoreboarded bench for am_mod: ramp targets and timing are queued per tick and checked on
// ramp completion; RF_out density is compared against the ideal duty cycle of the product.
module tb_am_mod;

    localparam int RAMP_LOG2 = 8;
    localparam int RAMP_LEN  = 1 << RAMP_LOG2;

    logic CLK  = 1'b0;
    logic RSTb = 1'b0;

    am_mod_if bus ();

    am_mod #(.RAMP_LOG2(RAMP_LOG2)) dut (
        .CLK  (CLK),
        .RSTb (RSTb),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned tickCyc;
        int          target;
    } rampExp_t;

    rampExp_t    expQ[$];
    int unsigned cyc      = 0;
    int          checks   = 0;
    int          errors   = 0;
    logic        prevBusy = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic longint floorDiv(longint a, longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int modelTarget(logic [15:0] audio, logic [2:0] depth);
        longint divisor;
        divisor = longint'(1) << (int'(depth) + 1);
        return 32768 + int'(floorDiv(longint'($signed(audio)), divisor));
    endfunction

    // Ideal ones per 1024 cycles: duty p satisfies p*32767 - (1-p)*32768 = prod.
    function automatic int modelOnes(int env, int cosv);
        longint p;
        real    duty;
        p    = floorDiv(longint'(env) * longint'(cosv), 65536);
        duty = real'(p + 32768) / 65535.0;
        return $rtoi(duty * 1024.0 + 0.5);
    endfunction

    task automatic checkOutput(string name, int actual, int expected, int tol);
        checks++;
        if (actual < expected - tol || actual > expected + tol) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d (+/-%0d)", name, actual, expected, tol);
        end
    endtask

    // Caller is at a negedge; the tick is sampled on the next rising edge.
    task automatic applyStimulus(logic [15:0] audio, logic [2:0] depth);
        rampExp_t e;
        bus.audio_in = audio;
        bus.depth    = depth;
        bus.in_tick  = 1'b1;
        e.tickCyc    = cyc + 1;
        e.target     = modelTarget(audio, depth);
        expQ.push_back(e);
        @(negedge CLK);
        bus.in_tick  = 1'b0;
    endtask

    task automatic waitIdle(string name);
        for (int i = 0; i < 800; i++) begin
            @(negedge CLK);
            #1;
            if (expQ.size() == 0 && !bus.ramp_busy) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s: ramp did not finish within 800 cycles", name);
        expQ.delete();
    endtask

    task automatic measureOnes(string name, logic [15:0] cosv, int expected, int tol);
        int ones;
        @(negedge CLK);
        bus.cos = cosv;
        repeat (32) @(negedge CLK);
        ones = 0;
        repeat (1024) begin
            @(negedge CLK);
            ones += int'(bus.RF_out);
        end
        checkOutput(name, ones, expected, tol);
    endtask

    // Monitor: a falling ramp_busy completes the newest queued ramp; older ones were superseded.
    always @(negedge CLK) begin : monitor
        rampExp_t e;
        if (RSTb && prevBusy && !bus.ramp_busy) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rampUnexpected: ramp ended at cycle %0d, want no ramp", cyc);
            end else begin
                e = expQ[$];
                expQ.delete();
                checkOutput("rampEnv", int'(dut.r_env_cur), e.target, 0);
                checkOutput("rampLen", int'(cyc - e.tickCyc), RAMP_LEN + 1, 0);
            end
        end
        prevBusy <= bus.ramp_busy;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] audio;
        logic [2:0]  depth;
        logic [15:0] cosv;
        int          lastTarget;
        int          busyCount;

        bus.audio_in = '0;
        bus.depth    = '0;
        bus.in_tick  = 1'b0;
        bus.cos      = '0;
        RSTb         = 1'b0;

        repeat (8) begin
            @(negedge CLK);
            bus.cos = 16'($urandom);
        end
        checkOutput("rstRF",   int'(bus.RF_out),    0,     0);
        checkOutput("rstBusy", int'(bus.ramp_busy), 0,     0);
        checkOutput("rstEnv",  int'(dut.r_env_cur), 32768, 0);

        @(negedge CLK);
        RSTb    = 1'b1;
        bus.cos = '0;
        measureOnes("onesCosZero", 16'h0000, 512, 1);
        measureOnes("onesCosMax",  16'h7FFF, modelOnes(32768, 32767), 2);
        checkOutput("onesCosMaxModel", modelOnes(32768, 32767), 768, 0);

        @(negedge CLK);
        applyStimulus(16'h7FFE, 3'd0);
        waitIdle("rampUp");
        @(negedge CLK);
        applyStimulus(16'h8000, 3'd0);
        waitIdle("rampDown");

        @(negedge CLK);
        applyStimulus(16'h7FFE, 3'd0);
        repeat (99) @(negedge CLK);
        applyStimulus(16'h0000, 3'd0);
        waitIdle("rampRestart");
        checkOutput("restartEnv", int'(dut.r_env_cur), 32768, 0);

        for (int i = 0; i < 8; i++) begin
            audio = 16'($urandom);
            depth = 3'($urandom_range(0, 7));
            @(negedge CLK);
            applyStimulus(audio, depth);
            lastTarget = modelTarget(audio, depth);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 180)) @(negedge CLK);
                audio = 16'($urandom);
                depth = 3'($urandom_range(0, 7));
                applyStimulus(audio, depth);
                lastTarget = modelTarget(audio, depth);
            end
            waitIdle("rampRandom");
            cosv = 16'($urandom);
            measureOnes("onesRandom", cosv, modelOnes(lastTarget, int'($signed(cosv))), 3);
        end

        @(negedge CLK);
        applyStimulus(16'h7FFE, 3'd0);
        repeat (50) @(negedge CLK);
        #2;
        RSTb = 1'b0;
        #1;
        expQ.delete();
        checkOutput("midRstRF",   int'(bus.RF_out),    0,     0);
        checkOutput("midRstBusy", int'(bus.ramp_busy), 0,     0);
        checkOutput("midRstEnv",  int'(dut.r_env_cur), 32768, 0);
        checkOutput("midRstProd", int'(dut.r_prod),    0,     0);
        repeat (3) @(negedge CLK);
        RSTb      = 1'b1;
        busyCount = 0;
        repeat (300) begin
            @(negedge CLK);
            busyCount += int'(bus.ramp_busy);
        end
        checkOutput("noResume",    busyCount,           0,     0);
        checkOutput("envAfterRst", int'(dut.r_env_cur), 32768, 0);

        @(negedge CLK);
        RSTb = 1'b0;
        @(negedge CLK);
        RSTb = 1'b1;
        applyStimulus(16'h8000, 3'd1);
        waitIdle("tickAfterRelease");
        checkOutput("tickAfterReleaseEnv", int'(dut.r_env_cur), 24576, 0);

        repeat (4) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/am_mod.md
AM_MOD -- requirements
Module: am_mod

Interface
REQ-001 Parameter RAMP_LOG2, default 8, log2 of the envelope ramp length in clock cycles (range 1..12).
REQ-002 CLK  input  1  system clock, 100 MHz; all state changes on its rising edge.
REQ-003 RSTb  input  1  reset; asynchronous, active-low.
REQ-004 audio_in  input  16  signed two's-complement baseband sample; valid when in_tick=1.
REQ-005 in_tick  input  1  single-cycle strobe marking a new audio_in sample.
REQ-006 depth  input  3  modulation-depth shift; sampled together with audio_in on in_tick.
REQ-007 cos  input  16  signed carrier from the nco block, one new value per cycle.
REQ-008 RF_out  output  1  registered 1-bit sigma-delta RF output.
REQ-009 ramp_busy  output  1  high while the envelope is ramping toward a new target.

Function
REQ-010 On in_tick, target SHALL load 16'h8000 + (audio_in >>> (depth+1)), an unsigned 16-bit value; its range is 16384..49151.
REQ-011 The cycle after target loads, the block SHALL set step = (target - env_cur) >>> RAMP_LOG2 (signed 17-bit), clear ramp_cnt and assert ramp_busy.
REQ-012 The block SHALL be a two-state FSM: HOLD (env_cur constant, ramp_busy=0) and RAMP (env_cur += step each cycle).
REQ-013 In RAMP, on the cycle ramp_cnt reaches 2^RAMP_LOG2-1, env_cur SHALL load target exactly (absorbing truncation) and the FSM SHALL return to HOLD.
REQ-014 An in_tick arriving during RAMP SHALL replace target, recompute step from the current env_cur, restart ramp_cnt at 0 and stay in RAMP.
REQ-015 An in_tick in the same cycle as ramp completion SHALL take priority: env_cur loads the old target and a new ramp starts toward the new target.
REQ-016 prod SHALL be registered as bits [31:16] of the signed product {1'b0,env_cur} x cos; 1 cycle latency, no overflow possible.
REQ-017 The sigma-delta SHALL be first order: acc (18-bit signed) <= acc + prod - fb, with fb = +32767 when RF_out=1 and -32768 when RF_out=0.
REQ-018 RF_out SHALL be registered as 1 when the new acc value is >= 0, else 0.
REQ-019 acc SHALL saturate to [-2^17, 2^17-1] and never wrap.
REQ-020 Latency from a cos/env_cur change to its first effect on RF_out SHALL be 2 cycles.

Reset
REQ-021 While RSTb=0: RF_out=0, ramp_busy=0, acc=0, prod=0, step=0, ramp_cnt=0, env_cur=target=16'h8000, FSM=HOLD.
REQ-022 A reset asserted mid-ramp SHALL abandon the ramp; after release the block SHALL wait for the next in_tick.
REQ-023 An in_tick in the first cycle after reset release SHALL be accepted normally.

Structure
REQ-024 The DC offset (16'h8000), feedback levels (+32767/-32768) and acc saturation limits SHALL be defined in the shared package am_pkg, shared with the receive chain.
REQ-025 The modulator loop (REQ-017..019) SHALL be the sub-module sd_mod1 (inputs CLK, RSTb, prod; output RF_out); the envelope FSM and multiply stay in am_mod.

Verification
REQ-026 Reset: hold RSTb low with cos toggling -> RF_out=0, ramp_busy=0, env_cur=16'h8000.
REQ-027 cos=0, no ticks -> RF_out alternates; 512 +/- 1 ones in any 1024-cycle window.
REQ-028 cos=16'h7FFF, env_cur=16'h8000 (prod=16'h3FFF) -> 768 +/- 2 ones in 1024 cycles.
REQ-029 audio_in=16'h7FFE, depth=0, one tick -> ramp_busy high for exactly 256 cycles, then env_cur=16'hBFFF; audio_in=16'h8000 -> env_cur=16'h4000.
REQ-030 Second tick (audio_in=0) 100 cycles into the ramp of REQ-029 -> ramp restarts; after 256 further cycles env_cur=16'h8000 exactly.
REQ-031 RSTb pulsed low 50 cycles into a ramp -> all REQ-021 values present within 1 cycle of assertion; no ramp resumes after release.
